fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end that feeds the decode stage. It issues sequential reads
//  to instruction memory and buffers the returned words with their PCs in a small
//  FIFO. It presents them to decode with a valid/ready handshake.
//  Decode/branch redirects flush the queue. A halt word ends fetch and raises
//  halt once decode consumes it.
// PARAMETERS
//  DEPTH       4              queue entries; power of 2, >= 2
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  HALT_INSTR  32'h0000_0073  instruction word treated as halt
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    asynchronous, active-high reset
//  imem_req     out  1                    read request this cycle (memory always accepts)
//  imem_addr    out  32                   request address (= fetch_pc)
//  imem_rdata   in   32                   read data, valid exactly 1 cycle after imem_req
//  redirect     in   1                    flush and refetch from redirect_pc
//  redirect_pc  in   32                   redirect target, word aligned
//  dec_ready    in   1                    decode accepts an instruction (= !stall)
//  instr_valid  out  1                    head entry presented to decode
//  instr        out  32                   head instruction word
//  pc           out  32                   PC of head instruction
//  halt         out  1                    sticky halt indication
//  occupancy    out  $clog2(DEPTH)+1      entries currently held
// BEHAVIOUR
//  Reset (async, immediate):
//  - fetch_pc=RESET_PC; queue empty; inflight=0; halt_seen=0; halt=0.
//  - instr_valid=0, instr=0, pc=0, occupancy=0, imem_req=0 while rst high.
//  Issue:
//  - imem_req = !rst & !redirect & !halt_seen & !halt & (occupancy + inflight < DEPTH).
//  - The credit check ignores a same-cycle pop, so overflow is impossible.
//  - On issue: fetch_pc += 4 (32-bit wrap); inflight<=1; inflight_pc<=fetch_pc.
//  - Otherwise inflight<=0.
//  Response:
//  - When inflight=1, imem_rdata and inflight_pc are pushed at the tail that cycle.
//  - Exception: redirect is high that cycle, and the response is dropped.
//  - A pushed word equal to HALT_INSTR sets halt_seen; no further requests.
//  Output:
//  - instr_valid = (occupancy!=0) & !halt.
//  - instr/pc come combinationally from the head entry; both are 0 when instr_valid=0.
//  - Pop when instr_valid & dec_ready. Push and pop in the same cycle leave occupancy unchanged.
//  Latency:
//  - A request in cycle N is visible at decode in cycle N+2 if the queue was empty.
//  - Sustained throughput is 1 instr/cycle with dec_ready held high.
//  Redirect (priority over push/pop):
//  - Queue cleared; in-flight response dropped; fetch_pc<=redirect_pc; halt_seen<=0.
//  - No request in the redirect cycle; first request to redirect_pc the next cycle.
//  - instr_valid=0 the cycle after redirect.
//  - Ignored once halt=1.
//  Halt:
//  - halt<=1 on the edge where the HALT_INSTR entry pops.
//  - Stays 1 until rst; no further requests; instr_valid=0.
//  Boundaries:
//  - Pointers wrap modulo DEPTH.
//  - Push at full or pop at empty is a design error (bench assertion).
//  - rst asserted mid-operation discards all entries and the in-flight response.
// TESTING
//  1. Release rst, dec_ready=1, imem_rdata=addr-tagged words
//     -> imem_addr 0,4,8.. every cycle; instr_valid from cycle 2; pc 0,4,8 in order.
//  2. dec_ready=0 for 10 cycles from start
//     -> exactly 4 requests (0..0xC), occupancy=4, imem_req=0.
//     Then dec_ready=1 -> pops 0,4,8,0xC in order; fetch resumes at 0x10.
//  3. Redirect to 0x100 with occupancy=3 and inflight=1
//     -> next cycle occupancy=0, instr_valid=0; stale word never delivered.
//     Next request addr 0x100; first delivered pc=0x100.
//  4. HALT_INSTR returned at 0x8
//     -> no request for 0xC or later; halt=1 the cycle after pc 0x8 pops; halt stays 1;
//     instr_valid=0 thereafter.
//  5. Halt word queued (not popped), then redirect to 0x40
//     -> halt never asserts; fetch resumes at 0x40; delivery continues normally.
//  6. rst pulsed mid-stream with occupancy=2
//     -> instr_valid=0 and occupancy=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          dec_ready;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   pc;
  logic          halt;
  logic [CW-1:0] occupancy;

  modport master (
    input  imem_rdata, redirect, redirect_pc, dec_ready,
    output imem_req, imem_addr, instr_valid, instr, pc, halt, occupancy
  );

  modport slave (
    output imem_rdata, redirect, redirect_pc, dec_ready,
    input  imem_req, imem_addr, instr_valid, instr, pc, halt, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a credit-limited FIFO toward decode,
// redirect flush and sticky halt on consumption of the halt word.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic          halt_seen_q, halt_seen_d;
  logic          halt_q, halt_d;

  logic   flush, push, halt_resp, credit_ok, issue, valid, pop;
  entry_t head;

  // A halted core ignores redirects; a redirect always suppresses issue.
  assign flush     = bus.redirect & ~halt_q;
  assign push      = inflight_q & ~flush;
  assign halt_resp = push & (bus.imem_rdata == HALT_INSTR);
  assign credit_ok = (count_q + CW'(inflight_q)) < CW'(DEPTH);
  assign issue     = ~rst & ~bus.redirect & ~halt_seen_q & ~halt_q & ~halt_resp & credit_ok;
  assign head      = mem_q[rptr_q];
  assign valid     = (count_q != '0) & ~halt_q;
  assign pop       = valid & bus.dec_ready & ~flush;

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? head.instr : 32'd0;
  assign bus.pc          = valid ? head.pc    : 32'd0;
  assign bus.halt        = halt_q;
  assign bus.occupancy   = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    halt_seen_d   = halt_seen_q;
    halt_d        = halt_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    count_d       = count_q;
    if (flush) begin
      rptr_d      = '0;
      wptr_d      = '0;
      count_d     = '0;
      fetch_pc_d  = bus.redirect_pc;
      halt_seen_d = 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (halt_resp) halt_seen_d = 1'b1;
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
        if (head.instr == HALT_INSTR) halt_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      halt_seen_q   <= 1'b0;
      halt_q        <= 1'b0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      halt_seen_q   <= halt_seen_d;
      halt_q        <= halt_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{instr: bus.imem_rdata, pc: inflight_pc_q};
  end
endmodule
